// File: rtl/tcdm_rr_arbiter.sv
// Round-robin, stall-locking arbiter sharing one TCDM slave port among N_REQ masters.
// Optional macro TCDM_ARB_WR_ACK_EN: writes are acknowledged with a local m_valid_o pulse.
module tcdm_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W/8,
  parameter int SRC_W  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               m_req_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   m_add_i,
  input  logic [N_REQ-1:0][BE_W-1:0]     m_be_i,
  input  logic [N_REQ-1:0]               m_opc_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]   m_din_i,
  output logic [N_REQ-1:0]               m_gnt_o,
  output logic [N_REQ-1:0][DATA_W-1:0]   m_dout_o,
  output logic [N_REQ-1:0]               m_valid_o,
  output logic                           s_req_o,
  output logic [ADDR_W-1:0]              s_add_o,
  output logic [BE_W-1:0]                s_be_o,
  output logic                           s_opc_o,
  output logic [DATA_W-1:0]              s_din_o,
  output logic [SRC_W-1:0]               s_src_o,
  input  logic                           s_gnt_i,
  input  logic [DATA_W-1:0]              s_dout_i,
  input  logic                           s_valid_i,
  output logic                           proto_err_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;
  logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
  logic             lock_q, lock_d;
  logic             rsp_pend_q, rsp_pend_d;
  logic             proto_err_q, proto_err_d;
  logic             rsp_wr_q, rsp_wr_d;

  logic [IDX_W-1:0] winner;
  logic             lock_hold, lock_viol, hs, stall;
  logic             rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  assign lock_hold = lock_q & m_req_i[lock_id_q];
  assign lock_viol = lock_q & ~m_req_i[lock_id_q];

  // A held lock wins outright; otherwise scan from rr_ptr with wrap-around.
  always_comb begin
    int               idx;
    logic             found;
    logic [IDX_W-1:0] idx_l;
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = 0;
    idx_l  = '0;
    if (lock_hold) begin
      winner = lock_id_q;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        idx_l = IDX_W'(idx);
        if (!found && m_req_i[idx_l]) begin
          winner = idx_l;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_req_o = |m_req_i;
    s_add_o = '0;
    s_be_o  = '0;
    s_opc_o = 1'b0;
    s_din_o = '0;
    s_src_o = '0;
    if (s_req_o) begin
      s_add_o = m_add_i[winner];
      s_be_o  = m_be_i[winner];
      s_opc_o = m_opc_i[winner];
      s_din_o = m_din_i[winner];
      s_src_o = SRC_W'(winner);
    end
    for (int i = 0; i < N_REQ; i++) begin
      m_gnt_o[i] = s_req_o & s_gnt_i & (winner == IDX_W'(i));
    end
  end

  assign hs    = s_req_o & s_gnt_i;
  assign stall = s_req_o & ~s_gnt_i;

  // Next-state: pointer advance, stall lock, outstanding-response tracking, sticky error.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    rsp_id_d   = rsp_id_q;
    rsp_pend_d = 1'b0;
    rsp_wr_d   = 1'b0;
    if (hs) begin
      rr_ptr_d = (winner == IDX_W'(N_REQ-1)) ? '0 : winner + 1'b1;
      lock_d   = 1'b0;
      rsp_id_d = winner;
    end else if (stall) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end
    if (lock_viol) lock_d = 1'b0;
`ifdef TCDM_ARB_WR_ACK_EN
    rsp_pend_d  = hs;
    rsp_wr_d    = hs & s_opc_o;
    proto_err_d = proto_err_q | lock_viol
                | (s_valid_i & ~rsp_pend_q)
                | (s_valid_i & rsp_pend_q & rsp_wr_q)
                | (rsp_pend_q & ~rsp_wr_q & ~s_valid_i);
`else
    rsp_pend_d  = hs & ~s_opc_o;
    proto_err_d = proto_err_q | lock_viol
                | (s_valid_i & ~rsp_pend_q)
                | (rsp_pend_q & ~s_valid_i);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      rsp_pend_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_wr_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_id_q    <= rsp_id_d;
      rsp_wr_q    <= rsp_wr_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Read data is steered only to the master that owns the outstanding response.
  always_comb begin
    rsp_valid = rsp_pend_q & s_valid_i;
    rsp_data  = s_dout_i;
`ifdef TCDM_ARB_WR_ACK_EN
    if (rsp_wr_q) begin
      rsp_valid = rsp_pend_q;
      rsp_data  = '0;
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      m_valid_o[i] = rsp_valid & (rsp_id_q == IDX_W'(i));
      m_dout_o[i]  = (rsp_pend_q && (rsp_id_q == IDX_W'(i))) ? rsp_data : '0;
    end
  end

  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Scoreboard bench for tcdm_rr_arbiter: directed traffic, a 1-cycle memory model,
// and a negedge monitor that checks every grant and response against queued expectations.
module tb_tcdm_rr_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int SRC_W  = 2;

  logic                          clk;
  logic                          rst;
  logic [N_REQ-1:0]              m_req_i;
  logic [N_REQ-1:0][ADDR_W-1:0]  m_add_i;
  logic [N_REQ-1:0][BE_W-1:0]    m_be_i;
  logic [N_REQ-1:0]              m_opc_i;
  logic [N_REQ-1:0][DATA_W-1:0]  m_din_i;
  logic [N_REQ-1:0]              m_gnt_o;
  logic [N_REQ-1:0][DATA_W-1:0]  m_dout_o;
  logic [N_REQ-1:0]              m_valid_o;
  logic                          s_req_o;
  logic [ADDR_W-1:0]             s_add_o;
  logic [BE_W-1:0]               s_be_o;
  logic                          s_opc_o;
  logic [DATA_W-1:0]             s_din_o;
  logic [SRC_W-1:0]              s_src_o;
  logic                          s_gnt_i;
  logic [DATA_W-1:0]             s_dout_i;
  logic                          s_valid_i;
  logic                          proto_err_o;

  tcdm_rr_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .SRC_W(SRC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_be_i(m_be_i), .m_opc_i(m_opc_i),
    .m_din_i(m_din_i), .m_gnt_o(m_gnt_o), .m_dout_o(m_dout_o), .m_valid_o(m_valid_o),
    .s_req_o(s_req_o), .s_add_o(s_add_o), .s_be_o(s_be_o), .s_opc_o(s_opc_o),
    .s_din_o(s_din_o), .s_src_o(s_src_o), .s_gnt_i(s_gnt_i), .s_dout_i(s_dout_i),
    .s_valid_i(s_valid_i), .proto_err_o(proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          exp_gnt_q[$];
  int          exp_rsp_id_q[$];
  logic [31:0] exp_rsp_dat_q[$];
  logic        inject_valid;
  logic [31:0] mem [int];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] mem_read(input int a);
    if (mem.exists(a)) return mem[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model: grant/valid protocol with read data exactly one cycle after the handshake.
  initial begin
    logic        rd, wr, inj;
    int          addr;
    logic [31:0] din;
    s_valid_i = 1'b0;
    s_dout_i  = '0;
    forever begin
      @(negedge clk);
      rd   = s_req_o & s_gnt_i & ~s_opc_o;
      wr   = s_req_o & s_gnt_i & s_opc_o;
      addr = int'(s_add_o);
      din  = s_din_o;
      inj  = inject_valid;
      @(posedge clk);
      #1;
      if (wr) mem[addr] = din;
      s_valid_i = rd | inj;
      s_dout_i  = rd ? mem_read(addr) : 32'h0;
    end
  end

  // Monitor: every presented grant or response must match the head of its queue.
  initial begin
    int          e;
    logic [31:0] d;
    logic [31:0] others;
    forever begin
      @(negedge clk);
      if (m_gnt_o != '0) begin
        if (exp_gnt_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_gnt: got 0x%0h expected none", m_gnt_o);
        end else begin
          e = exp_gnt_q.pop_front();
          checkOutput("gnt", 32'(m_gnt_o), 32'(1 << e));
        end
      end
      if (m_valid_o != '0) begin
        if (exp_rsp_id_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_valid: got 0x%0h expected none", m_valid_o);
        end else begin
          e = exp_rsp_id_q.pop_front();
          d = exp_rsp_dat_q.pop_front();
          checkOutput("valid", 32'(m_valid_o), 32'(1 << e));
          checkOutput("dout", m_dout_o[e], d);
          others = '0;
          for (int i = 0; i < N_REQ; i++) if (i != e) others |= m_dout_o[i];
          checkOutput("dout_others", others, 32'h0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] opc, input logic gnt);
    m_req_i = req;
    m_opc_i = opc;
    s_gnt_i = gnt;
  endtask

  task automatic expect_gnt(input int id);
    exp_gnt_q.push_back(id);
  endtask

  task automatic expect_rsp(input int id, input logic [31:0] data);
    exp_rsp_id_q.push_back(id);
    exp_rsp_dat_q.push_back(data);
  endtask

  initial begin
    logic [31:0] dout_or;
    rst          = 1'b1;
    inject_valid = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0);
    for (int i = 0; i < N_REQ; i++) begin
      m_add_i[i] = ADDR_W'(32'h100 + i);
      m_be_i[i]  = '1;
      m_din_i[i] = '0;
    end

    @(negedge clk);
    checkOutput("rst_s_req", 32'(s_req_o), 32'h0);
    checkOutput("rst_gnt", 32'(m_gnt_o), 32'h0);
    checkOutput("rst_valid", 32'(m_valid_o), 32'h0);
    checkOutput("rst_err", 32'(proto_err_o), 32'h0);
    step();
    rst = 1'b0;
    step();

    // All four masters reading back-to-back: grants rotate 0..3 twice.
    applyStimulus(4'hF, 4'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      expect_gnt(k % 4);
      expect_rsp(k % 4, 32'hC0DE0100 + 32'(k % 4));
      step();
    end
    applyStimulus(4'h0, 4'h0, 1'b0);
    step();
    step();

    // Move rr_ptr to 2, then masters 1 and 3 contend: 3 first, then 1.
    applyStimulus(4'b0010, 4'h0, 1'b1);
    expect_gnt(1); expect_rsp(1, 32'hC0DE0101);
    step();
    applyStimulus(4'b1010, 4'h0, 1'b1);
    expect_gnt(3); expect_rsp(3, 32'hC0DE0103);
    step();
    expect_gnt(1); expect_rsp(1, 32'hC0DE0101);
    step();
    applyStimulus(4'h0, 4'h0, 1'b0);
    step();

    // Stall on master 1; master 0 arrives mid-stall and must not steal the slot.
    applyStimulus(4'b0010, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("stall1_add", 32'(s_add_o), 32'h101);
    step();
    applyStimulus(4'b0011, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("stall2_add", 32'(s_add_o), 32'h101);
    checkOutput("stall2_src", 32'(s_src_o), 32'h1);
    step();
    @(negedge clk);
    checkOutput("stall3_add", 32'(s_add_o), 32'h101);
    step();
    applyStimulus(4'b0011, 4'h0, 1'b1);
    expect_gnt(1); expect_rsp(1, 32'hC0DE0101);
    step();
    applyStimulus(4'b0001, 4'h0, 1'b1);
    expect_gnt(0); expect_rsp(0, 32'hC0DE0100);
    step();
    applyStimulus(4'h0, 4'h0, 1'b0);
    step();

    // Master 2 writes 0xDEADBEEF to 0x10 and reads it back.
    m_add_i[2] = ADDR_W'(32'h10);
    m_din_i[2] = 32'hDEADBEEF;
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    expect_gnt(2);
`ifdef TCDM_ARB_WR_ACK_EN
    expect_rsp(2, 32'h0);
`endif
    step();
    applyStimulus(4'b0100, 4'h0, 1'b1);
    expect_gnt(2); expect_rsp(2, 32'hDEADBEEF);
    step();
    applyStimulus(4'h0, 4'h0, 1'b0);
    step();
    @(negedge clk);
    checkOutput("err_clean", 32'(proto_err_o), 32'h0);
    step();

    // Spurious s_valid_i with nothing outstanding sets the sticky error.
    inject_valid = 1'b1;
    step();
    inject_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_pre", 32'(proto_err_o), 32'h0);
    step();
    @(negedge clk);
    checkOutput("err_set", 32'(proto_err_o), 32'h1);
    repeat (3) step();
    @(negedge clk);
    checkOutput("err_sticky", 32'(proto_err_o), 32'h1);
    step();

    // Reset with a read outstanding: response is dropped and rr_ptr returns to 0.
    applyStimulus(4'b1000, 4'h0, 1'b1);
    expect_gnt(3);
    step();
    rst = 1'b1;
    applyStimulus(4'h0, 4'h0, 1'b0);
    #1;
    dout_or = '0;
    for (int i = 0; i < N_REQ; i++) dout_or |= m_dout_o[i];
    checkOutput("rstmid_valid", 32'(m_valid_o), 32'h0);
    checkOutput("rstmid_dout", dout_or, 32'h0);
    checkOutput("rstmid_err", 32'(proto_err_o), 32'h0);
    checkOutput("rstmid_s_req", 32'(s_req_o), 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    applyStimulus(4'b1001, 4'h0, 1'b1);
    expect_gnt(0); expect_rsp(0, 32'hC0DE0100);
    step();
    expect_gnt(3); expect_rsp(3, 32'hC0DE0103);
    step();
    applyStimulus(4'h0, 4'h0, 1'b0);
    step();
    @(negedge clk);
    checkOutput("err_after_rst", 32'(proto_err_o), 32'h0);
    step();

    // Locked master drops its request: slave side follows master 2, error flagged.
    applyStimulus(4'b0010, 4'h0, 1'b0);
    step();
    applyStimulus(4'b0100, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("viol_add", 32'(s_add_o), 32'h10);
    checkOutput("viol_src", 32'(s_src_o), 32'h2);
    step();
    applyStimulus(4'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("viol_err", 32'(proto_err_o), 32'h1);
    step();
    step();

    checkOutput("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'h0);
    checkOutput("rsp_queue_empty", 32'(exp_rsp_id_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
